// File: rtl/seq7seg_display_if.sv
// Control inputs and segment outputs of the two-digit sequence display.
interface seq7seg_display_if;
    logic       time_s;
    logic       up;
    logic [6:0] seg1;
    logic [6:0] seg0;

    modport master (output time_s, up, input seg1, seg0);
    modport slave  (input time_s, up, output seg1, seg0);
endinterface

// File: rtl/seq7seg_display.sv
// Steps through a fixed 8-value sequence and shows it on two 7-segment digits.
// Optional: SEQ7SEG_BLANK_LEADING_ZERO_EN blanks the tens digit when it is zero.
module cntdiv_n #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic nreset,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)          cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

module deco7seg_hexa #(
    parameter int N = 4
) (
    input  logic [N-1:0] digit,
    output logic [6:0]   seg
);
    always_comb begin
        seg = 7'h7F;
        if (digit <= N'(15)) begin
            case (digit[3:0])
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                default: seg = 7'h0E;
            endcase
        end
    end
endmodule

module seq7seg_display #(
    parameter int FPGA_F = 50_000_000,
    parameter int N      = 4
) (
    input logic               clk,
    input logic               nreset,
    seq7seg_display_if.slave  bus
);
    localparam int DIV = FPGA_F / 2;

    logic         tick;
    logic         phase;
    logic         step;
    logic [2:0]   index;
    logic [N-1:0] value;
    logic [N-1:0] tens;
    logic [1:0][N-1:0] digits;
    logic [1:0][6:0]   segs;

    cntdiv_n #(.DIV(DIV)) u_div (.clk(clk), .nreset(nreset), .tick(tick));

    // In 1 s mode only ticks seen with phase 0 advance the sequence.
    assign step = tick & (bus.time_s | ~phase);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            phase <= 1'b0;
            index <= 3'd0;
        end else begin
            if (tick) phase <= ~phase;
            if (step) index <= bus.up ? index + 3'd1 : index - 3'd1;
        end
    end

    always_comb begin
        value = '0;
        case (index)
            3'd0: value = N'(5);
            3'd1: value = N'(10);
            3'd2: value = N'(15);
            3'd3: value = N'(4);
            3'd4: value = N'(9);
            3'd5: value = N'(14);
            3'd6: value = N'(3);
            default: value = N'(8);
        endcase
    end

    assign tens      = value / N'(10);
    assign digits[1] = tens;
    assign digits[0] = value % N'(10);

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dec
            deco7seg_hexa #(.N(N)) u_dec (.digit(digits[g]), .seg(segs[g]));
        end
    endgenerate

`ifdef SEQ7SEG_BLANK_LEADING_ZERO_EN
    assign bus.seg1 = (tens == '0) ? 7'h7F : segs[1];
`else
    assign bus.seg1 = segs[1];
`endif
    assign bus.seg0 = segs[0];
endmodule

// File: tb/tb_seq7seg_display.sv
// Randomized bench for seq7seg_display with a tick-count reference model.
module tb_seq7seg_display;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    seq7seg_display_if bus ();

    seq7seg_display #(.FPGA_F(8), .N(4)) dut (.clk(clk), .nreset(nreset), .bus(bus));

    always #5 clk = ~clk;

    int         seq_v [8]  = '{5, 10, 15, 4, 9, 14, 3, 8};
    logic [6:0] seg_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: edges since release; every 4th edge is a tick, odd-numbered
    // ticks always step, even-numbered ones only in 0.5 s mode.
    int       edges;
    logic [2:0] m_idx;
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            edges = 0;
            m_idx = 3'd0;
        end else begin
            edges++;
            if (edges % 4 == 0) begin
                if (bus.time_s || ((edges / 4) % 2 == 1))
                    m_idx = bus.up ? m_idx + 3'd1 : m_idx - 3'd1;
            end
        end
    end

    function automatic logic [6:0] exp_seg1(input logic [2:0] i);
        int v = seq_v[i];
`ifdef SEQ7SEG_BLANK_LEADING_ZERO_EN
        if (v < 10) return 7'h7F;
`endif
        return seg_t[v / 10];
    endfunction

    function automatic logic [6:0] exp_seg0(input logic [2:0] i);
        return seg_t[seq_v[i] % 10];
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_seg1", bus.seg1, exp_seg1(m_idx));
        check("model_seg0", bus.seg0, exp_seg0(m_idx));
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [6:0] s1, input logic [6:0] s0);
        check({name, "_seg1"}, bus.seg1, s1);
        check({name, "_seg0"}, bus.seg0, s0);
    endtask

    task automatic restart(input logic ts, input logic u);
        #1 nreset = 1'b0;
        bus.time_s = ts;
        bus.up = u;
        clocks(2);
        nreset = 1'b1;
    endtask

`ifdef SEQ7SEG_BLANK_LEADING_ZERO_EN
    localparam logic [6:0] ZERO_T = 7'h7F;
`else
    localparam logic [6:0] ZERO_T = 7'h40;
`endif

    initial begin
        bus.time_s = 1'b1;
        bus.up = 1'b1;
        // Reset held across several would-be ticks
        clocks(1);
        pin("rst", ZERO_T, 7'h12);
        clocks(9);
        pin("rst_hold", ZERO_T, 7'h12);

        // 0.5 s forward: full lap
        nreset = 1'b1;
        clocks(3);
        pin("fwd_pre", ZERO_T, 7'h12);
        clocks(1);
        pin("fwd_10", 7'h79, 7'h40);
        clocks(4);
        pin("fwd_15", 7'h79, 7'h12);
        clocks(12);
        pin("fwd_14", 7'h79, 7'h19);
        clocks(12);
        pin("fwd_wrap", ZERO_T, 7'h12);

        // 1 s forward: every second tick steps
        restart(1'b0, 1'b1);
        clocks(4);
        pin("slow_t1", 7'h79, 7'h40);
        clocks(4);
        pin("slow_t2", 7'h79, 7'h40);
        clocks(4);
        pin("slow_t3", 7'h79, 7'h12);

        // Backward wrap
        restart(1'b1, 1'b0);
        clocks(4);
        pin("bwd_08", ZERO_T, 7'h00);
        clocks(4);
        pin("bwd_03", ZERO_T, 7'h30);

        // Asynchronous reset mid-count
        restart(1'b1, 1'b1);
        clocks(22);
        pin("mid_14", 7'h79, 7'h19);
        #1 nreset = 1'b0;
        #1;
        pin("async_rst", ZERO_T, 7'h12);
        clocks(1);
        nreset = 1'b1;
        clocks(3);
        pin("rel_pre", ZERO_T, 7'h12);
        clocks(1);
        pin("rel_step", 7'h79, 7'h40);

        // Random rate/direction changes and reset pulses
        for (int i = 0; i < 800; i++) begin
            clocks(1);
            if ($urandom_range(0, 7) == 0) bus.time_s = 1'($urandom);
            if ($urandom_range(0, 9) == 0) bus.up = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                nreset = 1'b0;
                #1;
                pin("rnd_rst", ZERO_T, 7'h12);
                clocks($urandom_range(1, 3));
                nreset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
